// File: rtl/fft_link_pkg.sv
// Shared FFT output link definitions: frame size, frame FSM states
// and the byte order both ends of the link agree on.
package fft_link_pkg;

  localparam int FRAME_BYTES_DEFAULT = 16;
  localparam int FFT_POINTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    HOLD
  } frame_state_e;

  localparam int IDX_OUT0_RE = 0;
  localparam int IDX_OUT0_IM = 1;
  localparam int IDX_OUT7_RE = 14;
  localparam int IDX_OUT7_IM = 15;

  // Bytes are interleaved re/im per output bin.
  function automatic int byte_index(input int bin, input bit im);
    return 2 * bin + int'(im);
  endfunction

endpackage

// File: rtl/spi_slave_byte_rx.sv
// SPI mode 0 byte receiver: 2-FF syncs, SCLK edge detect, MSB-first shift.
// Ports: clk/rst_n; spi_clk/spi_mosi/spi_cs_n in; byte_dv/byte_data out;
// bit_err (partial byte at CS_n rise); cs_high/cs_fall synchronized CS_n.
module spi_slave_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       byte_dv,
  output logic [7:0] byte_data,
  output logic       bit_err,
  output logic       cs_high,
  output logic       cs_fall
);

  logic [1:0] sclk_s;
  logic [1:0] mosi_s;
  logic [1:0] cs_s;
  logic       sclk_d;
  logic       cs_d;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic       rise;
  logic       cs_rise;

  assign rise    = sclk_s[1] & ~sclk_d;
  assign cs_rise = cs_s[1] & ~cs_d;
  assign cs_fall = ~cs_s[1] & cs_d;
  assign cs_high = cs_s[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s    <= 2'b00;
      mosi_s    <= 2'b00;
      cs_s      <= 2'b11;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      cnt       <= 3'd0;
      sh        <= 7'd0;
      byte_dv   <= 1'b0;
      byte_data <= 8'd0;
      bit_err   <= 1'b0;
    end else begin
      sclk_s  <= {sclk_s[0], spi_clk};
      mosi_s  <= {mosi_s[0], spi_mosi};
      cs_s    <= {cs_s[0], spi_cs_n};
      sclk_d  <= sclk_s[1];
      cs_d    <= cs_s[1];
      byte_dv <= 1'b0;
      bit_err <= 1'b0;
      if (cs_s[1]) begin
        cnt <= 3'd0;
        if (cs_rise && cnt != 3'd0)
          bit_err <= 1'b1;
      end else if (cs_fall) begin
        cnt <= 3'd0;
      end else if (rise) begin
        sh  <= {sh[5:0], mosi_s[1]};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          byte_dv   <= 1'b1;
          byte_data <= {sh, mosi_s[1]};
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_rx.sv
// FFT frame receiver: reassembles SPI bytes into a frame buffer, valid/ack.
// Ports: i_Clk, i_Rst_L, i_SPI_Clk/MOSI/CS_n, o_Frame_Valid, i_Frame_Ack,
// i_Rd_Addr/o_Rd_Data (1-cycle read), o_Err, o_Overrun; with
// FFT_RX_BYTE_STREAM_EN also o_Byte_DV/o_Byte per-byte stream.
module fft_frame_rx
  import fft_link_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int GAP_TIMEOUT = 400
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_CS_n,
  output logic       o_Frame_Valid,
  input  logic       i_Frame_Ack,
  input  logic [7:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic       o_Err,
  output logic       o_Overrun
`ifdef FFT_RX_BYTE_STREAM_EN
  ,
  output logic       o_Byte_DV,
  output logic [7:0] o_Byte
`endif
);

  localparam int AW = $clog2(FRAME_BYTES);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(FRAME_BYTES - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FRAME_BYTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          rx_err;
  logic          cs_high;
  logic          cs_fall;

  frame_state_e  state;
  frame_state_e  state_nx;
  logic [AW-1:0] idx;
  logic [GW-1:0] gap;
  logic          wr_en;
  logic          idx_inc;
  logic          idx_clr;
  logic          ovr_set;
  logic          ovr_clr;
  logic          gap_to;
  logic [AW-1:0] rd_idx;
  logic [7:0]    mem [FRAME_BYTES];

  spi_slave_byte_rx u_rx (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .spi_clk   (i_SPI_Clk),
    .spi_mosi  (i_SPI_MOSI),
    .spi_cs_n  (i_SPI_CS_n),
    .byte_dv   (rx_dv),
    .byte_data (rx_byte),
    .bit_err   (rx_err),
    .cs_high   (cs_high),
    .cs_fall   (cs_fall)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // cs_fall implies cs_high is low, so a fall in the
  // timeout cycle suppresses the timeout.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    idx_inc  = 1'b0;
    idx_clr  = 1'b0;
    ovr_set  = 1'b0;
    ovr_clr  = 1'b0;
    gap_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_dv) begin
          wr_en    = 1'b1;
          idx_inc  = 1'b1;
          state_nx = RECV;
        end
      end
      RECV: begin
        if (cs_high && gap == GAP_LAST) begin
          gap_to   = 1'b1;
          idx_clr  = 1'b1;
          state_nx = IDLE;
        end else if (rx_dv) begin
          wr_en = 1'b1;
          if (idx == LAST) begin
            idx_clr  = 1'b1;
            state_nx = HOLD;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      HOLD: begin
        if (i_Frame_Ack) begin
          ovr_clr  = 1'b1;
          state_nx = IDLE;
        end else if (rx_dv) begin
          ovr_set = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      idx       <= '0;
      gap       <= '0;
      o_Overrun <= 1'b0;
      o_Err     <= 1'b0;
    end else begin
      if (idx_clr)
        idx <= '0;
      else if (idx_inc)
        idx <= idx + AW'(1);
      if (state != RECV || !cs_high)
        gap <= '0;
      else
        gap <= gap + GW'(1);
      if (ovr_clr)
        o_Overrun <= 1'b0;
      else if (ovr_set)
        o_Overrun <= 1'b1;
      o_Err <= rx_err | gap_to;
    end
  end

  assign o_Frame_Valid = (state == HOLD);

  always_ff @(posedge i_Clk) begin
    if (wr_en)
      mem[idx] <= rx_byte;
  end

  assign rd_idx = i_Rd_Addr[AW-1:0];

  generate
    if (AW < 8) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_Rd_Addr[7:AW];
    end
  endgenerate

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      o_Rd_Data <= 8'd0;
    else if ({1'b0, rd_idx} < DEPTH)
      o_Rd_Data <= mem[rd_idx];
    else
      o_Rd_Data <= 8'd0;
  end

`ifdef FFT_RX_BYTE_STREAM_EN
  assign o_Byte_DV = rx_dv;
  assign o_Byte    = rx_byte;
`endif

endmodule

// File: tb/tb_fft_frame_rx.sv
// Directed bench for fft_frame_rx: frame capture, overrun/ack, gap timeout,
// partial byte, mid-frame reset, optional byte stream.
`timescale 1ns/1ps
module tb_fft_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rd_addr = 8'd0;
  logic       valid;
  logic [7:0] rd_data;
  logic       err;
  logic       ovr;
`ifdef FFT_RX_BYTE_STREAM_EN
  logic       bdv;
  logic [7:0] bval;
`endif

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int err_wide = 0;
  logic err_q = 1'b0;
  logic [7:0] f0 [16] = '{8'h00, 8'h52, 8'h7E, 8'h6E, 8'h2B, 8'hD5,
                          8'h92, 8'h82, 8'h01, 8'h02, 8'h03, 8'h04,
                          8'h05, 8'h06, 8'h07, 8'h08};

  fft_frame_rx dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_SPI_Clk     (sclk),
    .i_SPI_MOSI    (mosi),
    .i_SPI_CS_n    (cs_n),
    .o_Frame_Valid (valid),
    .i_Frame_Ack   (ack),
    .i_Rd_Addr     (rd_addr),
    .o_Rd_Data     (rd_data),
    .o_Err         (err),
    .o_Overrun     (ovr)
`ifdef FFT_RX_BYTE_STREAM_EN
    ,
    .o_Byte_DV     (bdv),
    .o_Byte        (bval)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (err && err_q) err_wide++;
    err_q = err;
  end

`ifdef FFT_RX_BYTE_STREAM_EN
  int dv_cnt = 0;
  logic [7:0] dv_last = 8'd0;
  always @(negedge clk) begin
    if (bdv) begin
      dv_cnt++;
      dv_last = bval;
    end
  end
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input int gap);
    cs_n = 1'b0;
    tick(3);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
    end
    tick(3);
    cs_n = 1'b1;
    tick(gap);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int gap);
    spi_bits(b, 8, gap);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk);
    #1 rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(5);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err);
    else passed++;
    checks++;
    if (ovr !== 1'b0) $display("FAIL rst_ovr got %b want 0", ovr);
    else passed++;
    checks++;
    if (rd_data !== 8'h00) $display("FAIL rst_rd got %h want 00", rd_data);
    else passed++;
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_frame();
    logic [7:0] d;
    int bad;
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 15; i++) spi_byte(f0[i], 100);
    checks++;
    if (valid !== 1'b0) $display("FAIL frame_early got %b want 0", valid);
    else passed++;
    spi_byte(f0[15], 100);
    checks++;
    if (valid !== 1'b1) $display("FAIL frame_valid got %b want 1", valid);
    else passed++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd(8'(i), d);
      if (d !== f0[i]) begin
        $display("FAIL frame_rd[%0d] got %h want %h", i, d, f0[i]);
        bad++;
      end
    end
    checks++;
    if (bad == 0) passed++;
    checks++;
    if (err_cnt !== e0) $display("FAIL frame_err got %0d want %0d", err_cnt, e0);
    else passed++;
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    spi_byte(8'hFF, 20);
    @(negedge clk);
    checks++;
    if (ovr !== 1'b1) $display("FAIL ovr_set got %b want 1", ovr);
    else passed++;
    checks++;
    if (valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", valid);
    else passed++;
    rd(8'd0, d);
    checks++;
    if (d !== 8'h00) $display("FAIL ovr_buf0 got %h want 00", d);
    else passed++;
    rd(8'd15, d);
    checks++;
    if (d !== 8'h08) $display("FAIL ovr_buf15 got %h want 08", d);
    else passed++;
    pulse_ack();
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) $display("FAIL ack_valid got %b want 0", valid);
    else passed++;
    checks++;
    if (ovr !== 1'b0) $display("FAIL ack_ovr got %b want 0", ovr);
    else passed++;
  endtask

  task automatic test_gap_timeout();
    logic [7:0] d;
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) spi_byte(8'hE0 + 8'(i), 20);
    tick(430);
    checks++;
    if (err_cnt !== e0 + 1) $display("FAIL gap_err got %0d want %0d", err_cnt - e0, 1);
    else passed++;
    checks++;
    if (err_wide !== 0) $display("FAIL gap_err_width got %0d want 0", err_wide);
    else passed++;
    for (int i = 0; i < 11; i++) spi_byte(8'h10 + 8'(i), 20);
    checks++;
    if (valid !== 1'b0) $display("FAIL gap_discard got %b want 0", valid);
    else passed++;
    for (int i = 11; i < 16; i++) spi_byte(8'h10 + 8'(i), 20);
    checks++;
    if (valid !== 1'b1) $display("FAIL gap_valid got %b want 1", valid);
    else passed++;
    rd(8'd0, d);
    checks++;
    if (d !== 8'h10) $display("FAIL gap_buf0 got %h want 10", d);
    else passed++;
    rd(8'd5, d);
    checks++;
    if (d !== 8'h15) $display("FAIL gap_buf5 got %h want 15", d);
    else passed++;
    pulse_ack();
    tick(2);
  endtask

  task automatic test_partial();
    logic [7:0] d;
    int e0;
    e0 = err_cnt;
    spi_bits(8'hB0, 5, 20);
    checks++;
    if (err_cnt !== e0 + 1) $display("FAIL part_err got %0d want %0d", err_cnt - e0, 1);
    else passed++;
    spi_byte(8'hA5, 20);
    for (int i = 1; i < 15; i++) spi_byte(8'h40 + 8'(i), 20);
    checks++;
    if (valid !== 1'b0) $display("FAIL part_nostrobe got %b want 0", valid);
    else passed++;
    spi_byte(8'h4F, 20);
    checks++;
    if (valid !== 1'b1) $display("FAIL part_valid got %b want 1", valid);
    else passed++;
    rd(8'd0, d);
    checks++;
    if (d !== 8'hA5) $display("FAIL part_buf0 got %h want a5", d);
    else passed++;
    rd(8'd1, d);
    checks++;
    if (d !== 8'h41) $display("FAIL part_buf1 got %h want 41", d);
    else passed++;
    pulse_ack();
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    for (int i = 0; i < 9; i++) spi_byte(8'hC0 + 8'(i), 20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", valid);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL rmid_err got %b want 0", err);
    else passed++;
    rst_n = 1'b1;
    tick(5);
    for (int i = 0; i < 7; i++) spi_byte(8'h60 + 8'(i), 20);
    checks++;
    if (valid !== 1'b0) $display("FAIL rmid_discard got %b want 0", valid);
    else passed++;
    for (int i = 7; i < 16; i++) spi_byte(8'h60 + 8'(i), 20);
    checks++;
    if (valid !== 1'b1) $display("FAIL rmid_frame got %b want 1", valid);
    else passed++;
    rd(8'd0, d);
    checks++;
    if (d !== 8'h60) $display("FAIL rmid_buf0 got %h want 60", d);
    else passed++;
    rd(8'd15, d);
    checks++;
    if (d !== 8'h6F) $display("FAIL rmid_buf15 got %h want 6f", d);
    else passed++;
    pulse_ack();
    tick(2);
  endtask

`ifdef FFT_RX_BYTE_STREAM_EN
  task automatic test_byte_stream();
    int c0;
    c0 = dv_cnt;
    spi_byte(8'h3C, 20);
    checks++;
    if (dv_cnt !== c0 + 1) $display("FAIL stream_cnt got %0d want 1", dv_cnt - c0);
    else passed++;
    checks++;
    if (dv_last !== 8'h3C) $display("FAIL stream_byte got %h want 3c", dv_last);
    else passed++;
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_gap_timeout();
    test_partial();
    test_reset_mid();
`ifdef FFT_RX_BYTE_STREAM_EN
    test_byte_stream();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
